// File: rtl/scr1_imem_router_np.sv
// scr1_imem_router_np: N-port IMEM router with mask/pattern decode and in-order outstanding fetch tracking.
// Define SCR1_IMEM_ROUTER_DECERR_EN to answer unmatched addresses locally with RDY_ER instead of the default port.

package scr1_imem_router_np_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'b00,
    SCR1_MEM_CMD_WR    = 2'b01,
    SCR1_MEM_CMD_ERROR = 2'b11
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Port i decodes to i<<16; sliced down to the configured port count.
  localparam logic [8*SCR1_IMEM_AWIDTH-1:0] SCR1_ROUTER_PATTERN_DFLT = {
    32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
    32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
  };

endpackage

module scr1_imem_router_np
  import scr1_imem_router_np_pkg::*;
#(
  parameter int SCR1_PORT_NUM     = 4,
  parameter int SCR1_OUTSTD_DEPTH = 2,
  parameter logic [SCR1_PORT_NUM*SCR1_IMEM_AWIDTH-1:0] SCR1_ADDR_MASK =
    {SCR1_PORT_NUM{32'hFFFF_0000}},
  parameter logic [SCR1_PORT_NUM*SCR1_IMEM_AWIDTH-1:0] SCR1_ADDR_PATTERN =
    SCR1_ROUTER_PATTERN_DFLT[SCR1_PORT_NUM*SCR1_IMEM_AWIDTH-1:0],
  parameter int SCR1_DFLT_PORT    = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  output logic                                      imem_req_ack,
  input  logic                                      imem_req,
  input  type_scr1_mem_cmd_e                        imem_cmd,
  input  logic [SCR1_IMEM_AWIDTH-1:0]               imem_addr,
  output logic [SCR1_IMEM_DWIDTH-1:0]               imem_rdata,
  output type_scr1_mem_resp_e                       imem_resp,
  input  logic [SCR1_PORT_NUM-1:0]                  port_req_ack,
  output logic [SCR1_PORT_NUM-1:0]                  port_req,
  output type_scr1_mem_cmd_e                        port_cmd [SCR1_PORT_NUM],
  output logic [SCR1_PORT_NUM*SCR1_IMEM_AWIDTH-1:0] port_addr,
  input  logic [SCR1_PORT_NUM*SCR1_IMEM_DWIDTH-1:0] port_rdata,
  input  type_scr1_mem_resp_e                       port_resp [SCR1_PORT_NUM]
);

  localparam int AW = SCR1_IMEM_AWIDTH;
  localparam int DW = SCR1_IMEM_DWIDTH;
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
  localparam int IDX_W = $clog2(SCR1_PORT_NUM + 1);
`else
  localparam int IDX_W = $clog2(SCR1_PORT_NUM);
`endif
  localparam int PTR_W = (SCR1_OUTSTD_DEPTH > 1) ? $clog2(SCR1_OUTSTD_DEPTH) : 1;
  localparam int CNT_W = $clog2(SCR1_OUTSTD_DEPTH + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam idx_t DFLT_IDX = idx_t'(SCR1_DFLT_PORT);
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
  localparam idx_t DECERR_IDX = idx_t'(SCR1_PORT_NUM);
`endif
  localparam ptr_t PTR_LAST = ptr_t'(SCR1_OUTSTD_DEPTH - 1);
  localparam cnt_t CNT_MAX  = cnt_t'(SCR1_OUTSTD_DEPTH);

  idx_t                fifo [SCR1_OUTSTD_DEPTH];
  ptr_t                rd_ptr;
  ptr_t                wr_ptr;
  cnt_t                cnt;
  idx_t                last_port;

  idx_t                sel;
  idx_t                head_port;
  type_scr1_mem_resp_e head_resp;
  logic [DW-1:0]       head_rdata;
  logic                sel_ack;
  logic                pop;
  logic                push;
  logic                allow;
  cnt_t                eff_cnt;

  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Address decode: the lowest matching port wins, so scan downwards.
  always_comb begin
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    sel = DECERR_IDX;
`else
    sel = DFLT_IDX;
`endif
    for (int i = SCR1_PORT_NUM - 1; i >= 0; i--) begin
      if ((imem_addr & SCR1_ADDR_MASK[i*AW +: AW]) == SCR1_ADDR_PATTERN[i*AW +: AW]) begin
        sel = idx_t'(i);
      end
    end
  end

  assign head_port = fifo[rd_ptr];

  always_comb begin
    head_resp  = SCR1_MEM_RESP_NOTRDY;
    head_rdata = '0;
    for (int i = 0; i < SCR1_PORT_NUM; i++) begin
      if (head_port == idx_t'(i)) begin
        head_resp  = port_resp[i];
        head_rdata = port_rdata[i*DW +: DW];
      end
    end
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    if (head_port == DECERR_IDX) begin
      head_resp = SCR1_MEM_RESP_RDY_ER;
    end
`endif
    if (cnt == '0) begin
      head_resp  = SCR1_MEM_RESP_NOTRDY;
      head_rdata = '0;
    end
  end

  assign imem_resp  = head_resp;
  assign imem_rdata = head_rdata;

  assign pop     = (head_resp == SCR1_MEM_RESP_RDY_OK) | (head_resp == SCR1_MEM_RESP_RDY_ER);
  assign eff_cnt = cnt - cnt_t'(pop);
  // Switching targets only once everything older has drained keeps responses in order.
  assign allow   = (eff_cnt < CNT_MAX) & ((eff_cnt == '0) | (sel == last_port));

  always_comb begin
    sel_ack = 1'b0;
    for (int i = 0; i < SCR1_PORT_NUM; i++) begin
      port_req[i] = imem_req & allow & (sel == idx_t'(i));
      port_cmd[i] = (sel == idx_t'(i)) ? imem_cmd : SCR1_MEM_CMD_ERROR;
      if (sel == idx_t'(i)) begin
        sel_ack = port_req_ack[i];
      end
    end
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    if (sel == DECERR_IDX) begin
      sel_ack = 1'b1;
    end
`endif
  end

  assign imem_req_ack = imem_req & allow & sel_ack;
  assign push         = imem_req_ack;
  assign port_addr    = {SCR1_PORT_NUM{imem_addr}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      last_port <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= ptr_next(wr_ptr);
        last_port <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push & ~pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop & ~push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= sel;
    end
  end

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> !$isunknown({imem_addr, imem_cmd}));
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_MAX);
`endif

endmodule

// File: tb/tb_scr1_imem_router_np.sv
// Randomized bench for scr1_imem_router_np: an in-order queue model predicts every output each cycle,
// and directed scenarios pin the model with literal expectations.
module tb_scr1_imem_router_np;
  import scr1_imem_router_np_pkg::*;

  localparam int P = 4;
  localparam int D = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                imem_req_ack;
  logic                imem_req;
  type_scr1_mem_cmd_e  imem_cmd;
  logic [31:0]         imem_addr;
  logic [31:0]         imem_rdata;
  type_scr1_mem_resp_e imem_resp;
  logic [P-1:0]        port_req_ack;
  logic [P-1:0]        port_req;
  type_scr1_mem_cmd_e  port_cmd [P];
  logic [P*32-1:0]     port_addr;
  logic [P*32-1:0]     port_rdata;
  type_scr1_mem_resp_e port_resp [P];

  int total = 0;
  int bad   = 0;
  int q[$];
  int last_port = 0;

  always #5 clk = ~clk;

  scr1_imem_router_np #(
    .SCR1_PORT_NUM    (P),
    .SCR1_OUTSTD_DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req_ack(imem_req_ack),
    .imem_req    (imem_req),
    .imem_cmd    (imem_cmd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .port_req_ack(port_req_ack),
    .port_req    (port_req),
    .port_cmd    (port_cmd),
    .port_addr   (port_addr),
    .port_rdata  (port_rdata),
    .port_resp   (port_resp)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port i owns the 64 KiB window i<<16; anything else is unmatched.
  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < P; i++) begin
      if (a[31:16] == 16'(i)) return i;
    end
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    return P;
`else
    return 0;
`endif
  endfunction

  // Reference: the queue holds the target of every accepted, unanswered fetch, oldest first.
  always @(negedge clk) begin
    int sel;
    int head;
    int eff;
    bit pop;
    bit allow;
    bit exp_ack;
    logic [P-1:0] exp_req;
    type_scr1_mem_resp_e exp_resp;
    logic [31:0] exp_rdata;
    logic [2*P-1:0] act_cmd;
    logic [2*P-1:0] exp_cmd;
    logic [P*32-1:0] exp_addr;
    if (!rst_n) begin
      q.delete();
      last_port = 0;
    end
    sel       = model_sel(imem_addr);
    exp_resp  = SCR1_MEM_RESP_NOTRDY;
    exp_rdata = '0;
    if (q.size() != 0) begin
      head = q[0];
      if (head == P) begin
        exp_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        exp_resp  = port_resp[head];
        exp_rdata = port_rdata[head*32 +: 32];
      end
    end
    pop     = (exp_resp != SCR1_MEM_RESP_NOTRDY);
    eff     = q.size() - int'(pop);
    allow   = (eff < D) && (eff == 0 || sel == last_port);
    exp_req = '0;
    if (imem_req && allow && sel < P) exp_req[sel] = 1'b1;
    exp_ack = imem_req && allow && (sel == P || port_req_ack[sel]);
    for (int i = 0; i < P; i++) begin
      act_cmd[2*i +: 2]   = port_cmd[i];
      exp_cmd[2*i +: 2]   = (i == sel) ? imem_cmd : SCR1_MEM_CMD_ERROR;
      exp_addr[i*32 +: 32] = imem_addr;
    end
    chk("imem_resp", imem_resp, exp_resp);
    chk("imem_rdata", imem_rdata, exp_rdata);
    chk("port_req", port_req, exp_req);
    chk("imem_req_ack", imem_req_ack, exp_ack);
    chk("port_cmd", act_cmd, exp_cmd);
    chk("port_addr", port_addr, exp_addr);
    if (rst_n) begin
      if (pop) void'(q.pop_front());
      if (exp_ack) begin
        q.push_back(sel);
        last_port = sel;
      end
    end
  end

  task automatic idle();
    imem_req     = 1'b0;
    imem_cmd     = SCR1_MEM_CMD_RD;
    imem_addr    = '0;
    port_req_ack = '0;
    port_rdata   = '0;
    for (int i = 0; i < P; i++) port_resp[i] = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [P-1:0] ack);
    idle();
    imem_req     = 1'b1;
    imem_addr    = a;
    port_req_ack = ack;
  endtask

  initial begin
    int cur_port;
    int r;
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    at_neg();
    chk("reset_resp", imem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("reset_req_ack", imem_req_ack, 1'b0);

    // Single fetch to port 2, answered the following cycle.
    step(); fetch(32'h0002_0004, 4'b0100); at_neg();
    chk("t1_port_req", port_req, 4'b0100);
    chk("t1_ack", imem_req_ack, 1'b1);
    chk("t1_model_count", q.size(), 1);
    step(); idle(); port_resp[2] = SCR1_MEM_RESP_RDY_OK; port_rdata[2*32 +: 32] = 32'hDEAD_BEEF; at_neg();
    chk("t1_rdata", imem_rdata, 32'hDEAD_BEEF);
    chk("t1_resp", imem_resp, SCR1_MEM_RESP_RDY_OK);
    step(); idle(); at_neg();
    chk("t1_drained", imem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("t1_model_empty", q.size(), 0);

    // Streaming on port 1: one acceptance per cycle, responses one cycle behind.
    for (int k = 0; k < 4; k++) begin
      step();
      idle();
      if (k < 3) fetch(32'h0001_0000 + 32'(4*k), 4'b0010);
      if (k >= 1) begin
        port_resp[1] = SCR1_MEM_RESP_RDY_OK;
        port_rdata[1*32 +: 32] = 32'hA000_0000 + 32'(k-1);
      end
      at_neg();
      if (k < 3) chk("stream_ack", imem_req_ack, 1'b1);
      if (k >= 1) chk("stream_rdata", imem_rdata, 32'hA000_0000 + 32'(k-1));
    end

    // Port switch waits until both port-1 fetches have returned.
    step(); fetch(32'h0001_0000, 4'b0010);
    step(); fetch(32'h0001_0004, 4'b0010); at_neg();
    chk("sw_second_ack", imem_req_ack, 1'b1);
    step(); fetch(32'h0003_0000, 4'b1000); at_neg();
    chk("sw_stall_req", port_req, 4'b0000);
    chk("sw_stall_ack", imem_req_ack, 1'b0);
    step(); fetch(32'h0003_0000, 4'b1000); port_resp[1] = SCR1_MEM_RESP_RDY_OK; at_neg();
    chk("sw_one_left_req", port_req, 4'b0000);
    step(); fetch(32'h0003_0000, 4'b1000); port_resp[1] = SCR1_MEM_RESP_RDY_OK; at_neg();
    chk("sw_issue_req", port_req, 4'b1000);
    chk("sw_issue_ack", imem_req_ack, 1'b1);
    step(); idle(); port_resp[3] = SCR1_MEM_RESP_RDY_OK; port_rdata[3*32 +: 32] = 32'h0000_0033; at_neg();
    chk("sw_p3_rdata", imem_rdata, 32'h0000_0033);

    // Error response does not disturb the younger fetch.
    step(); fetch(32'h0000_0000, 4'b0001);
    step(); fetch(32'h0000_0004, 4'b0001);
    step(); idle(); port_resp[0] = SCR1_MEM_RESP_RDY_ER; port_rdata[31:0] = 32'h11; at_neg();
    chk("er_first", imem_resp, SCR1_MEM_RESP_RDY_ER);
    step(); idle(); port_resp[0] = SCR1_MEM_RESP_RDY_OK; port_rdata[31:0] = 32'h22; at_neg();
    chk("er_second", imem_resp, SCR1_MEM_RESP_RDY_OK);
    chk("er_second_rdata", imem_rdata, 32'h22);
    step(); idle(); at_neg();
    chk("er_drained", imem_resp, SCR1_MEM_RESP_NOTRDY);

    // Unmatched address.
    step(); fetch(32'hFFFF_0000, 4'b0001); at_neg();
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    chk("nomatch_req", port_req, 4'b0000);
`else
    chk("nomatch_req", port_req, 4'b0001);
`endif
    chk("nomatch_ack", imem_req_ack, 1'b1);
    step(); idle(); port_resp[0] = SCR1_MEM_RESP_RDY_OK; port_rdata[31:0] = 32'h55; at_neg();
`ifdef SCR1_IMEM_ROUTER_DECERR_EN
    chk("nomatch_resp", imem_resp, SCR1_MEM_RESP_RDY_ER);
    chk("nomatch_rdata", imem_rdata, 32'h0);
`else
    chk("nomatch_resp", imem_resp, SCR1_MEM_RESP_RDY_OK);
    chk("nomatch_rdata", imem_rdata, 32'h55);
`endif

    // Reset with two fetches in flight; a late response is ignored.
    step(); fetch(32'h0001_0000, 4'b0010);
    step(); fetch(32'h0001_0004, 4'b0010);
    step(); idle(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    step(); idle(); port_resp[1] = SCR1_MEM_RESP_RDY_OK; port_rdata[1*32 +: 32] = 32'h77; at_neg();
    chk("rst_late_resp", imem_resp, SCR1_MEM_RESP_NOTRDY);
    chk("rst_late_rdata", imem_rdata, 32'h0);
    chk("rst_model_empty", q.size(), 0);

    // Randomized traffic with occasional resets.
    cur_port = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n    = ($urandom_range(0, 299) != 0);
      imem_req = ($urandom_range(0, 9) < 7);
      imem_cmd = $urandom_range(0, 1) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      if ($urandom_range(0, 9) < 4) cur_port = $urandom_range(0, P);
      if (cur_port == P) imem_addr = 32'hF000_0000 | ($urandom & 32'h00FF_FFFC);
      else imem_addr = {16'(cur_port), 16'($urandom & 32'hFFFC)};
      for (int i = 0; i < P; i++) begin
        port_req_ack[i] = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 19);
        port_resp[i] = (r < 10) ? SCR1_MEM_RESP_NOTRDY :
                       (r < 17) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
        port_rdata[i*32 +: 32] = $urandom;
      end
    end
    step(); idle(); rst_n = 1'b1;
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
